// File: rtl/pipe_hazard_if.sv
// Status and control bundle between the pipeline datapath and the hazard sequencer.
// master = datapath side (drives stage status), slave = sequencer (drives controls).
interface pipe_hazard_if;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic [3:0] id_rs;
  logic [3:0] id_rt;
  logic       id_r0read;
  logic       id_r1read;
  logic       ex_memread;
  logic [3:0] ex_dst;
  logic       mem_branch_taken;
  logic       wb_ret;
  logic       dmem_busy;

  logic       pc_we;
  logic [1:0] pc_sel;
  logic       if_id_we;
  logic       id_ex_we;
  logic       ex_mem_we;
  logic       mem_wb_we;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_mem_flush;
  logic       stall;
  logic       halted;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_r0read, id_r1read,
           ex_memread, ex_dst, mem_branch_taken, wb_ret, dmem_busy,
    input  pc_we, pc_sel, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, ex_mem_flush, stall, halted
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_r0read, id_r1read,
           ex_memread, ex_dst, mem_branch_taken, wb_ret, dmem_busy,
    output pc_we, pc_sel, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, ex_mem_flush, stall, halted
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use stall, CALL/RET redirect, branch squash, HLT drain, dmem freeze.
// Per-cycle controls are combinational from state and inputs; only state, cnt and halted are flops.
module pipe_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst,
  pipe_hazard_if.slave bus
);

  typedef enum logic [1:0] {RUN, RET_WAIT, DRAIN, HALTED} state_t;

  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [1:0] SEL_INC  = 2'b00;
  localparam logic [1:0] SEL_CALL = 2'b01;
  localparam logic [1:0] SEL_BR   = 2'b10;
  localparam logic [1:0] SEL_RET  = 2'b11;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic       halted_q;
  logic       load_use;

  assign load_use = bus.id_valid && bus.ex_memread && (bus.ex_dst != 4'd0) &&
                    ((bus.id_r0read && (bus.id_rs == bus.ex_dst)) ||
                     (bus.id_r1read && (bus.id_rt == bus.ex_dst)));

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path can infer a latch.
    bus.pc_we        = 1'b1;
    bus.pc_sel       = SEL_INC;
    bus.if_id_we     = 1'b1;
    bus.id_ex_we     = 1'b1;
    bus.ex_mem_we    = 1'b1;
    bus.mem_wb_we    = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_flush = 1'b0;
    bus.stall        = 1'b0;
    state_n          = state;
    cnt_n            = cnt;

    if (rst || (!bus.dmem_busy && state == HALTED)) begin
      bus.pc_we     = 1'b0;
      bus.if_id_we  = 1'b0;
      bus.id_ex_we  = 1'b0;
      bus.ex_mem_we = 1'b0;
      bus.mem_wb_we = 1'b0;
    end else if (bus.dmem_busy) begin
      bus.pc_we     = 1'b0;
      bus.if_id_we  = 1'b0;
      bus.id_ex_we  = 1'b0;
      bus.ex_mem_we = 1'b0;
      bus.mem_wb_we = 1'b0;
      bus.stall     = 1'b1;
    end else if (bus.mem_branch_taken) begin
      // Anything younger than the branch (including a pending RET/HLT) is squashed.
      bus.pc_sel       = SEL_BR;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      bus.ex_mem_flush = 1'b1;
      state_n          = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (load_use) begin
            bus.pc_we       = 1'b0;
            bus.if_id_we    = 1'b0;
            bus.id_ex_flush = 1'b1;
            bus.stall       = 1'b1;
          end else if (bus.id_valid) begin
            unique case (bus.id_opcode)
              OP_CALL: begin
                bus.pc_sel      = SEL_CALL;
                bus.if_id_flush = 1'b1;
              end
              OP_RET: begin
                bus.pc_we       = 1'b0;
                bus.if_id_flush = 1'b1;
                state_n         = RET_WAIT;
              end
              OP_HLT: begin
                bus.pc_we       = 1'b0;
                bus.if_id_flush = 1'b1;
                cnt_n           = 3'(DRAIN_CYCLES - 1);
                state_n         = DRAIN;
              end
              default: ;
            endcase
          end
        end
        RET_WAIT: begin
          bus.if_id_flush = 1'b1;
          if (bus.wb_ret) begin
            bus.pc_sel = SEL_RET;
            state_n    = RUN;
          end else begin
            bus.pc_we = 1'b0;
          end
        end
        DRAIN: begin
          bus.pc_we       = 1'b0;
          bus.if_id_flush = 1'b1;
          if (cnt == 3'd0) state_n = HALTED;
          else             cnt_n   = cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      state    <= state_n;
      cnt      <= cnt_n;
      halted_q <= (state_n == HALTED);
    end
  end

  assign bus.halted = halted_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencer for the 5-stage 16-bit CPU. Watches decode, execute, memory and writeback status and drives the PC and pipeline-register enables/flushes. It resolves four hazards: load-use stalls, CALL redirect, RET wait-for-writeback, and taken-branch squash. It also handles the HLT drain and data-memory wait freezes. A small FSM holds the multi-cycle RET and HLT sequences; per-cycle controls are combinational from state and inputs.

## Interface
- DRAIN_CYCLES, 3: cycles after HLT leaves ID before `halted` asserts (range 1-7).
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- id_valid  input  1  ID holds a real (non-flushed) instruction.
- id_opcode  input  4  opcode in ID (C=B, D=CALL, E=RET, F=HLT).
- id_rs, id_rt  input  4 each  source register addresses in ID.
- id_r0read, id_r1read  input  1 each  ID actually reads rs / rt.
- ex_memread  input  1  instruction in EX is a load.
- ex_dst  input  4  destination register in EX.
- mem_branch_taken  input  1  branch in MEM resolved taken.
- wb_ret  input  1  RET in WB; return address valid this cycle.
- dmem_busy  input  1  data memory not ready; freeze pipeline.
- pc_we  output  1  PC loads next value.
- pc_sel  output  2  00 PC+1, 01 call target, 10 branch target, 11 return address.
- if_id_we, id_ex_we, ex_mem_we, mem_wb_we  output  1 each  stage register enables.
- if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  register loads NOP; overrides its enable.
- stall  output  1  ID held this cycle.
- halted  output  1  core halted.

## Operation
- States: RUN, RET_WAIT, DRAIN, HALTED. 3-bit down-counter `cnt` is used in DRAIN.
- Default in RUN: all `*_we`=1, all flushes=0, pc_sel=00, stall=0.
- Priority, highest first: rst, dmem_busy, mem_branch_taken, state-specific actions, load-use, CALL/RET/HLT decode.
- dmem_busy (any state): all enables=0, flushes=0, pc_we=0, stall=1. State and cnt hold.
- mem_branch_taken (not frozen): pc_sel=10, pc_we=1, flush IF/ID, ID/EX and EX/MEM. Next state RUN from RUN, RET_WAIT or DRAIN; the squashed RET or HLT was younger than the branch.
- Load-use (RUN only): id_valid & ex_memread & ex_dst!=0 & ((id_r0read & id_rs==ex_dst) | (id_r1read & id_rt==ex_dst)).
  - Response: pc_we=0, if_id_we=0, id_ex_flush=1, stall=1.
  - Exactly one bubble; forwarding covers MEM→EX afterwards.
  - Suppresses CALL/RET/HLT decode this cycle.
- CALL (RUN, id_valid, opcode D): pc_sel=01, pc_we=1, if_id_flush=1. State stays RUN.
- RET (RUN, id_valid, opcode E): pc_we=0, if_id_flush=1; RET advances to EX. Next state RET_WAIT.
- RET_WAIT: pc_we=0, if_id_flush=1 every cycle.
  - On wb_ret: pc_sel=11, pc_we=1, next state RUN.
  - No timeout.
- HLT (RUN, id_valid, opcode F): pc_we=0, if_id_flush=1, cnt←DRAIN_CYCLES-1, next state DRAIN.
- DRAIN: pc_we=0, if_id_flush=1.
  - cnt decrements each non-frozen cycle.
  - Next state HALTED when cnt==0.
- HALTED: every enable and pc_we=0, flushes=0, halted=1. Only rst exits.
- wb_ret or branch inputs in HALTED are ignored.
- `halted` is a registered decode of state==HALTED.

## Timing
- Reset (rst high, async): state=RUN, cnt=0, halted=0. While rst is asserted: all enables=0, flushes=0, pc_we=0, pc_sel=00, stall=0.
- Control outputs are combinational; state and cnt change on the rising clk edge.
- Load-use costs 1 cycle. CALL costs 1 bubble.
- RET, unfrozen: RET in ID at cycle t, wb_ret at t+3, PC loaded at edge ending t+3. Cost 3 bubbles; each dmem_busy cycle adds 1.
- HLT in ID at t: halted=1 from cycle t+DRAIN_CYCLES+1.
- Branch taken in the same cycle as load-use, CALL, RET or HLT decode: branch wins, and the younger event is discarded.
- rst mid-RET_WAIT or mid-DRAIN: immediate return to RUN. No partial redirect is issued.

## Test plan
- Load-use: ex_memread=1, ex_dst=3; ID opcode 0 with id_rs=3, id_r0read=1 → one cycle of stall=1, pc_we=0, id_ex_flush=1. Same with ex_dst=0 → no stall.
- CALL: id_opcode=D, id_valid=1 → pc_sel=01, pc_we=1, if_id_flush=1 for 1 cycle. State remains RUN.
- RET: opcode E at cycle 0, wb_ret at cycle 3 → pc_we=0 in cycles 0-2, pc_sel=11 with pc_we=1 in cycle 3. Repeat with dmem_busy in cycle 1 → redirect waits for wb_ret in cycle 4.
- Branch in RET_WAIT: mem_branch_taken=1 in cycle 1 after RET → pc_sel=10, three flushes=1, state RUN. A later stray wb_ret is not acted on.
- HLT, DRAIN_CYCLES=3: opcode F at cycle 0 → halted=1 at cycle 4, all enables 0. Then rst pulse → halted=0, state RUN.
- Freeze during DRAIN: dmem_busy high 2 cycles mid-drain → halted is delayed exactly 2 cycles, and all enables are 0 during the freeze.
